// File: rtl/ansi_key_pkg.sv
// Shared definitions for the ANSI terminal key decoder: key codes, FSM states
// and the byte values the decoder recognises.
package ansi_key_pkg;

  typedef enum logic [3:0] {
    KEY_NONE  = 4'd0,
    KEY_SPACE = 4'd1,
    KEY_ENTER = 4'd2,
    KEY_UP    = 4'd3,
    KEY_DOWN  = 4'd4,
    KEY_RIGHT = 4'd5,
    KEY_LEFT  = 4'd6,
    KEY_ESC   = 4'd7,
    KEY_ALT   = 4'd8,
    KEY_CHAR  = 4'd9
  } key_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ESC  = 2'd1,
    ST_CSI  = 2'd2,
    ST_SS3  = 2'd3
  } state_t;

  localparam logic [7:0] BYTE_ESC   = 8'h1B;
  localparam logic [7:0] BYTE_SPACE = 8'h20;
  localparam logic [7:0] BYTE_CR    = 8'h0D;
  localparam logic [7:0] BYTE_LF    = 8'h0A;
  localparam logic [7:0] BYTE_LBRK  = 8'h5B;
  localparam logic [7:0] BYTE_O     = 8'h4F;
  localparam logic [7:0] BYTE_SEMI  = 8'h3B;
  localparam logic [7:0] BYTE_R     = 8'h52;
  localparam logic [7:0] BYTE_0     = 8'h30;
  localparam logic [7:0] BYTE_9     = 8'h39;

  // Final bytes 'A'..'D' of SS3/CSI arrow sequences; anything else is KEY_NONE.
  function automatic key_t arrow_key(input logic [7:0] b);
    case (b)
      8'h41:   return KEY_UP;
      8'h42:   return KEY_DOWN;
      8'h43:   return KEY_RIGHT;
      8'h44:   return KEY_LEFT;
      default: return KEY_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ansi_key_decoder_if.sv
// Byte-in / event-out bundle of the key decoder; the decoder is the slave,
// whoever feeds terminal bytes and consumes events is the master.
interface ansi_key_decoder_if;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] key_char;
  logic       cpr_valid;
  logic [7:0] cpr_row;
  logic [7:0] cpr_col;
  logic       err;

  modport master (
    output in_valid, in_byte,
    input  key_valid, key_code, key_char, cpr_valid, cpr_row, cpr_col, err
  );

  modport slave (
    input  in_valid, in_byte,
    output key_valid, key_code, key_char, cpr_valid, cpr_row, cpr_col, err
  );
endinterface

// File: rtl/ansi_num_acc.sv
// Saturating decimal accumulator for one numeric CSI parameter field.
module ansi_num_acc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       digit_stb,
  input  logic [3:0] digit,
  output logic [7:0] value
);

  logic [11:0] next_value;

  // 255*10+9 fits in 12 bits, so the product never wraps before saturation.
  assign next_value = ({4'd0, value} * 12'd10) + {8'd0, digit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= 8'd0;
    end else if (clear) begin
      value <= 8'd0;
    end else if (digit_stb) begin
      value <= (next_value > 12'd255) ? 8'hFF : next_value[7:0];
    end
  end

endmodule

// File: rtl/ansi_key_decoder.sv
// Decodes a raw terminal byte stream into key events, cursor position
// reports and error pulses, resolving stalled escape sequences by timeout.
module ansi_key_decoder
  import ansi_key_pkg::*;
#(
  parameter int ESC_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ansi_key_decoder_if.slave    bus
);

  localparam int TIMER_W = (ESC_TIMEOUT < 2) ? 1 : $clog2(ESC_TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ESC_TIMEOUT - 1);

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic               field_idx;
  logic [7:0]         b;
  logic               accept;
  logic               is_digit;
  logic               acc_clear;
  logic               csi_digit;
  logic [7:0]         field0;
  logic [7:0]         field1;
  key_t               arrow;

  assign b         = bus.in_byte;
  assign accept    = bus.in_valid && (b != 8'h00);
  assign is_digit  = (b >= BYTE_0) && (b <= BYTE_9);
  assign arrow     = arrow_key(b);
  assign acc_clear = accept && (state == ST_ESC) && (b == BYTE_LBRK);
  assign csi_digit = accept && (state == ST_CSI) && is_digit;

  ansi_num_acc u_field0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (acc_clear),
    .digit_stb (csi_digit && !field_idx),
    .digit     (b[3:0]),
    .value     (field0)
  );

  ansi_num_acc u_field1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (acc_clear),
    .digit_stb (csi_digit && field_idx),
    .digit     (b[3:0]),
    .value     (field1)
  );

  // A byte always wins over the timer, so a timeout only fires on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      timer         <= '0;
      field_idx     <= 1'b0;
      bus.key_valid <= 1'b0;
      bus.key_code  <= KEY_NONE;
      bus.key_char  <= 8'h00;
      bus.cpr_valid <= 1'b0;
      bus.cpr_row   <= 8'h00;
      bus.cpr_col   <= 8'h00;
      bus.err       <= 1'b0;
    end else begin
      bus.key_valid <= 1'b0;
      bus.cpr_valid <= 1'b0;
      bus.err       <= 1'b0;
      if (accept) begin
        timer <= '0;
        case (state)
          ST_IDLE: begin
            if (b == BYTE_ESC) begin
              state <= ST_ESC;
            end else begin
              bus.key_valid <= 1'b1;
              bus.key_char  <= 8'h00;
              if (b == BYTE_SPACE) begin
                bus.key_code <= KEY_SPACE;
              end else if ((b == BYTE_CR) || (b == BYTE_LF)) begin
                bus.key_code <= KEY_ENTER;
              end else begin
                bus.key_code <= KEY_CHAR;
                bus.key_char <= b;
              end
            end
          end
          ST_ESC: begin
            if (b == BYTE_LBRK) begin
              state     <= ST_CSI;
              field_idx <= 1'b0;
            end else if (b == BYTE_O) begin
              state <= ST_SS3;
            end else if (b == BYTE_ESC) begin
              bus.key_valid <= 1'b1;
              bus.key_code  <= KEY_ESC;
              bus.key_char  <= 8'h00;
            end else begin
              state         <= ST_IDLE;
              bus.key_valid <= 1'b1;
              bus.key_code  <= KEY_ALT;
              bus.key_char  <= b;
            end
          end
          ST_SS3: begin
            state <= ST_IDLE;
            if (arrow != KEY_NONE) begin
              bus.key_valid <= 1'b1;
              bus.key_code  <= arrow;
              bus.key_char  <= 8'h00;
            end else begin
              bus.err <= 1'b1;
            end
          end
          ST_CSI: begin
            if (is_digit) begin
              state <= ST_CSI;
            end else if ((b == BYTE_SEMI) && !field_idx) begin
              field_idx <= 1'b1;
            end else begin
              state <= ST_IDLE;
              if (arrow != KEY_NONE) begin
                bus.key_valid <= 1'b1;
                bus.key_code  <= arrow;
                bus.key_char  <= 8'h00;
              end else if ((b == BYTE_R) && field_idx) begin
                bus.cpr_valid <= 1'b1;
                bus.cpr_row   <= field0;
                bus.cpr_col   <= field1;
              end else begin
                bus.err <= 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        if (timer == TIMER_LAST) begin
          timer <= '0;
          state <= ST_IDLE;
          if (state == ST_ESC) begin
            bus.key_valid <= 1'b1;
            bus.key_code  <= KEY_ESC;
            bus.key_char  <= 8'h00;
          end else begin
            bus.err <= 1'b1;
          end
        end else begin
          timer <= timer + TIMER_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/ansi_key_decoder.md
ANSI_KEY_DECODER -- requirements
Module: ansi_key_decoder

Interface
REQ-001 SHALL have parameter ESC_TIMEOUT, default 8, meaning idle cycles after a lone ESC (or a stalled sequence) before it is resolved.
REQ-002 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  in_byte is a terminal input byte this cycle.
REQ-005 SHALL have port in_byte  input  8  raw byte from the stdin reader.
REQ-006 SHALL have port key_valid  output  1  one-cycle pulse: key_code/key_char are new.
REQ-007 SHALL have port key_code  output  4  decoded key: NONE, SPACE, ENTER, UP, DOWN, RIGHT, LEFT, ESC, ALT, CHAR.
REQ-008 SHALL have port key_char  output  8  raw byte for CHAR/ALT, else 0.
REQ-009 SHALL have port cpr_valid  output  1  one-cycle pulse: cursor position report decoded.
REQ-010 SHALL have port cpr_row  output  8  reported row, saturated.
REQ-011 SHALL have port cpr_col  output  8  reported column, saturated.
REQ-012 SHALL have port err  output  1  one-cycle pulse: malformed or timed-out sequence dropped.

Function
REQ-013 SHALL ignore cycles with in_valid=0 and bytes 0x00 even when in_valid=1.
REQ-014 SHALL implement states IDLE, ESC, CSI, SS3.
REQ-015 IDLE: 0x20 -> SPACE; 0x0D/0x0A -> ENTER; 0x1B -> ESC state, timer cleared; any other byte -> CHAR, key_char=byte.
REQ-016 ESC: '[' -> CSI, both fields and field index cleared; 'O' -> SS3; 0x1B -> emit ESC key, stay ESC, timer cleared; any other byte -> emit ALT, key_char=byte, IDLE.
REQ-017 SS3: 'A','B','C','D' -> UP, DOWN, RIGHT, LEFT; any other byte -> err, IDLE.
REQ-018 CSI: '0'-'9' -> field = field*10 + digit, saturating at 255; ';' with index 0 -> index 1; ';' with index 1 -> err, IDLE.
REQ-019 CSI final byte: 'A'-'D' -> arrow key as SS3 (parameters ignored); 'R' with index 1 -> cpr_valid, cpr_row=field0, cpr_col=field1; 'R' with index 0 -> err; any other byte -> err; all return to IDLE.
REQ-020 Timer SHALL count idle cycles in ESC/CSI/SS3, clear on each accepted byte; at ESC_TIMEOUT: ESC state emits ESC key, CSI/SS3 pulse err; all return to IDLE.
REQ-021 All outputs SHALL be registered; events appear exactly one cycle after the accepting clock edge (or timeout edge).
REQ-022 key_valid, cpr_valid, err SHALL be single-cycle pulses; at most one of the three per cycle.
REQ-023 key_code/key_char SHALL hold their last values between pulses; cpr_row/cpr_col likewise.
REQ-024 Back-to-back bytes (in_valid every cycle) SHALL be accepted without stall; no backpressure exists.
REQ-025 A byte arriving in the same cycle the timer expires SHALL take priority; the timeout is discarded.

Reset
REQ-026 On rst_n=0: state IDLE, timer 0, fields 0, index 0, all outputs 0 (key_code=NONE), asynchronously.
REQ-027 Reset mid-sequence SHALL discard the partial sequence with no err pulse; decoding resumes in IDLE after release.

Structure
REQ-028 Key codes, state encoding, and byte constants (ESC 0x1B, SPACE, CR, LF, '[', 'O', ';', 'R') SHALL live in shared package ansi_key_pkg, also used by the controller.
REQ-029 The saturating decimal accumulator SHALL be sub-module ansi_num_acc (clear, digit strobe, 4-bit digit, 8-bit saturating value).

Verification
REQ-030 Bytes 0x20, then 'q' -> key_valid twice: SPACE, then CHAR with key_char=0x71.
REQ-031 0x1B,'[','A' back-to-back, then 0x1B,'O','D' -> UP then LEFT, one cycle after each final byte; no err.
REQ-032 0x1B then silence for ESC_TIMEOUT cycles -> single ESC key pulse; 0x1B,'x' -> ALT, key_char=0x78.
REQ-033 "\033[12;40R" -> cpr_valid, row 12, col 40; "\033[999;7R" -> row 255, col 7.
REQ-034 "\033[5;6;7R", "\033[5R", and "\033[" then timeout -> one err pulse each, decoder back in IDLE.
REQ-035 rst_n pulsed low after "\033[3" -> outputs 0, no err; following 'A' decodes as CHAR 0x41.
